// File: rtl/hilo_pkg.sv
// hilo_pkg -- shared types for the HI/LO multiply/divide unit.
//   hilo_op_t    : 4-bit operation code carried on the ctrl port
//   hilo_state_t : sequencing state of the iterative datapath
//   is_signed_op : true for the two's-complement flavours of mul/div/accumulate
package hilo_pkg;

   typedef enum logic [3:0] {
      OP_NONE  = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MADD  = 4'd5,
      OP_MADDU = 4'd6,
      OP_MSUB  = 4'd7,
      OP_MSUBU = 4'd8,
      OP_MTHI  = 4'd9,
      OP_MTLO  = 4'd10
   } hilo_op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIX  = 2'd3
   } hilo_state_t;

   function automatic logic is_signed_op(input hilo_op_t op);
      return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
   endfunction

endpackage

// File: rtl/hilo_div_core.sv
// hilo_div_core -- unsigned restoring divider, one quotient bit per step.
//   clk, reset          : clock, synchronous active-high reset
//   load                : capture dividend/divisor and clear the partial remainder
//   step                : retire one quotient bit (WIDTH steps give the result)
//   dividend, divisor   : unsigned operands, sampled on load
//   quotient, remainder : result, valid after WIDTH steps
module hilo_div_core #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   // quo_q starts as the dividend and is shifted out from the top while
   // quotient bits are shifted in at the bottom.
   logic [WIDTH-1:0] quo_q, rem_q, dvs_q;
   logic [WIDTH:0]   rem_shift, diff;
   logic [WIDTH-1:0] quo_nxt, rem_nxt;

   always_comb begin
      rem_shift = {rem_q, quo_q[WIDTH-1]};
      diff      = rem_shift - {1'b0, dvs_q};
      // diff[WIDTH] set means the trial subtraction borrowed: restore.
      quo_nxt   = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
      rem_nxt   = diff[WIDTH] ? rem_shift[WIDTH-1:0] : diff[WIDTH-1:0];
   end

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         quo_q <= '0;
         rem_q <= '0;
         dvs_q <= '0;
      end else if (load) begin
         quo_q <= dividend;
         rem_q <= '0;
         dvs_q <= divisor;
      end else if (step) begin
         quo_q <= quo_nxt;
         rem_q <= rem_nxt;
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q;

endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv -- iterative HI/LO multiply/divide unit.
//   clk, reset : clock, synchronous active-high reset
//   start,ctrl : issue request and operation code (hilo_op_t)
//   a, b       : operands (a is dividend and MTHI/MTLO source)
//   flush      : abort the operation in flight, HI/LO untouched
//   busy       : an iterative operation is in flight
//   done       : one-cycle pulse when an iterative op writes HI/LO
//   hi, lo     : architectural HI/LO registers
// Build option: define HILO_MADD_EN to include MADD/MADDU/MSUB/MSUBU and the
// accumulate adder; otherwise those opcodes are ignored like NONE.
module hilo_muldiv
   import hilo_pkg::*;
#(
   parameter int WIDTH    = 32,
   parameter int MUL_BITS = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       ctrl,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int DW        = 2 * WIDTH;
   localparam int MUL_ITERS = WIDTH / MUL_BITS;
   localparam int CNT_W     = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_ITERS - 1);
   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(WIDTH - 1);

   hilo_state_t      state, state_nxt;
   hilo_op_t         op, op_q;
   logic [CNT_W-1:0] cnt;
   logic [DW-1:0]    acc, mcand, partial, prod, res;
   logic [WIDTH-1:0] mplier, a_q, a_mag, b_mag, quo, rem, div_quo, div_rem;
   logic             accept, is_mul, is_div, a_neg, b_neg;
   logic             neg_q, rem_neg_q, dz_q, wr_en;

   // ---------------------------------------------------------------- decode + FSM
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the block leaves it unassigned (which would infer a latch).
      op        = hilo_op_t'(ctrl);
      accept    = start && !busy && !flush;
      is_mul    = (op == OP_MULT) || (op == OP_MULTU);
`ifdef HILO_MADD_EN
      is_mul    = is_mul || (op == OP_MADD) || (op == OP_MADDU) ||
                  (op == OP_MSUB) || (op == OP_MSUBU);
`endif
      is_div    = (op == OP_DIV) || (op == OP_DIVU);
      state_nxt = state;
      wr_en     = 1'b0;
      case (state)
         IDLE: if (accept && is_mul)      state_nxt = MUL;
               else if (accept && is_div) state_nxt = (b == '0) ? FIX : DIV;
         MUL:  if (cnt == MUL_LAST)       state_nxt = FIX;
         DIV:  if (cnt == DIV_LAST)       state_nxt = FIX;
         FIX:  begin
                  state_nxt = IDLE;
                  wr_en     = 1'b1;
               end
         default: state_nxt = IDLE;
      endcase
      // Flush beats both a new issue and the completion write.
      if (flush) begin
         state_nxt = IDLE;
         wr_en     = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   assign busy = (state != IDLE);

   // ---------------------------------------------------------------- operand prep
   // Signed ops run on magnitudes; -MIN wraps to MIN, which is the correct
   // unsigned magnitude 2^(WIDTH-1).
   always_comb begin
      a_neg = is_signed_op(op) && a[WIDTH-1];
      b_neg = is_signed_op(op) && b[WIDTH-1];
      a_mag = a_neg ? -a : a;
      b_mag = b_neg ? -b : b;
   end

   hilo_div_core #(.WIDTH(WIDTH)) u_div (
      .clk       (clk),
      .reset     (reset),
      .load      (accept && is_div && (b != '0)),
      .step      (state == DIV),
      .dividend  (a_mag),
      .divisor   (b_mag),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   // ---------------------------------------------------------------- datapath comb
   always_comb begin
      // Shift-add: retire MUL_BITS multiplier bits per cycle.
      partial = '0;
      for (int k = 0; k < MUL_BITS; k++) begin
         if (mplier[k]) partial = partial + (mcand << k);
      end
      prod = neg_q ? -acc : acc;
      quo  = neg_q ? -div_quo : div_quo;
      rem  = rem_neg_q ? -div_rem : div_rem;
      case (op_q)
         OP_DIV, OP_DIVU:   res = dz_q ? {a_q, {WIDTH{1'b1}}} : {rem, quo};
`ifdef HILO_MADD_EN
         OP_MADD, OP_MADDU: res = {hi, lo} + prod;
         OP_MSUB, OP_MSUBU: res = {hi, lo} - prod;
`endif
         default:           res = prod;
      endcase
   end

   // ---------------------------------------------------------------- datapath regs
   always_ff @(posedge clk) begin
      if (reset) begin
         op_q      <= OP_NONE;
         cnt       <= '0;
         acc       <= '0;
         mcand     <= '0;
         mplier    <= '0;
         a_q       <= '0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         dz_q      <= 1'b0;
         done      <= 1'b0;
         hi        <= '0;
         lo        <= '0;
      end else begin
         done <= 1'b0;
         if (accept && (op == OP_MTHI)) hi <= a;
         if (accept && (op == OP_MTLO)) lo <= a;
         if (accept && (is_mul || is_div)) begin
            op_q      <= op;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= {{WIDTH{1'b0}}, a_mag};
            mplier    <= b_mag;
            a_q       <= a;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            dz_q      <= is_div && (b == '0);
         end else if (state == MUL) begin
            acc    <= acc + partial;
            mcand  <= mcand << MUL_BITS;
            mplier <= mplier >> MUL_BITS;
            cnt    <= cnt + 1'b1;
         end else if (state == DIV) begin
            cnt <= cnt + 1'b1;
         end
         if (wr_en) begin
            {hi, lo} <= res;
            done     <= 1'b1;
         end
      end
   end

endmodule

// File: doc/hilo_muldiv.md
HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and HI/LO width; legal values 8..64, even.
REQ-002 SHALL have parameter MUL_BITS, default 2, multiplier bits retired per cycle; legal values 1, 2, 4; WIDTH divisible by MUL_BITS.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to issue the operation on ctrl.
REQ-006 SHALL have port ctrl, input, 4 bits: operation code, hilo_op_t.
REQ-007 SHALL have ports a and b, inputs, WIDTH bits each: operands; a is the dividend and MTHI/MTLO source.
REQ-008 SHALL have port flush, input, 1 bit: abort the in-flight operation.
REQ-009 SHALL have port busy, output, 1 bit: iterative operation in flight.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse when HI/LO is written by an iterative operation.
REQ-011 SHALL have ports hi and lo, outputs, WIDTH bits each: architectural HI/LO registers.

Function
REQ-012 SHALL accept start only when busy=0 and flush=0; start while busy SHALL be ignored without effect.
REQ-013 Opcodes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MADD=5, MADDU=6, MSUB=7, MSUBU=8, MTHI=9, MTLO=10; codes 11..15 and NONE SHALL be ignored.
REQ-014 MTHI/MTLO SHALL write a to hi/lo on the accepting edge; busy and done SHALL stay 0.
REQ-015 Multiply ops: busy SHALL be high for WIDTH/MUL_BITS iteration cycles plus 1 finalize cycle; at the end of finalize, {hi,lo} is written, busy falls, and done=1 for one cycle.
REQ-016 Divide ops: busy SHALL be high for WIDTH iteration cycles plus 1 sign-fixup cycle; then write/done as in REQ-015.
REQ-017 Signed ops SHALL operate on magnitudes; the product and quotient are negated when operand signs differ; the remainder takes the dividend's sign.
REQ-018 Division SHALL set lo=quotient and hi=remainder; MIN/-1 SHALL give lo=MIN, hi=0.
REQ-019 Divide by zero SHALL be detected at accept, with busy for exactly 1 cycle, then hi=a and lo=all-ones, with done pulsed.
REQ-020 MADD/MSUB SHALL compute {hi,lo} ± the 2*WIDTH-bit product, modulo 2^(2*WIDTH), using hi/lo as held at the write cycle.
REQ-021 flush SHALL have priority over start and completion in the same cycle: busy=0 next cycle, hi/lo unchanged, no done.
REQ-022 Operands and op SHALL be registered at accept; a and b may change freely while busy.

Reset
REQ-023 reset SHALL clear hi, lo, busy, done, and all internal iteration state to 0 on the next edge, aborting any operation mid-flight.
REQ-024 reset SHALL take priority over flush and start.

Configuration
REQ-025 Macro HILO_MADD_EN SHALL compile in MADD/MADDU/MSUB/MSUBU; when it is undefined, opcodes 5..8 SHALL be ignored like NONE and the accumulate adder SHALL be absent.

Structure
REQ-026 Package hilo_pkg SHALL hold hilo_op_t (4-bit enum, REQ-013 values) and the state enum IDLE/MUL/DIV/FIX.
REQ-027 The FSM SHALL go IDLE->MUL|DIV on accept, MUL|DIV->FIX after the last iteration, and FIX->IDLE with write; any state ->IDLE on flush or reset.
REQ-028 A sub-module hilo_div_core (unsigned restoring divider, one bit per cycle) SHALL be used; the multiplier SHALL be inline shift-add.

Verification
REQ-029 WIDTH=32, MUL_BITS=2, MULT a=-3, b=7 -> busy for 17 cycles, then hi=FFFFFFFF, lo=FFFFFFEB, done pulsed once.
REQ-030 DIV a=-7, b=2 -> busy for 33 cycles, then lo=FFFFFFFD, hi=FFFFFFFF; DIVU a=7, b=0 -> busy 1 cycle, hi=7, lo=FFFFFFFF.
REQ-031 hi=0, lo=10, MADDU a=3, b=4 -> lo=22; MSUBU a=5, b=5 -> {hi,lo}=FFFFFFFF_FFFFFFFD; with HILO_MADD_EN undefined -> no busy, hi/lo unchanged.
REQ-032 DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
REQ-033 MULT issued, flush at busy cycle 5 -> busy=0 next cycle, hi/lo unchanged, no done; same-cycle start+flush -> nothing accepted.
REQ-034 Start while busy with MTHI -> hi unchanged; reset mid-DIV -> all outputs 0 next cycle.
